// File: rtl/replica_pkg.sv
// Shared types for the replica move path: move command, city index and the opt_t
// record handed from opt_gen to metropolis, plus the xorshift64 step helpers.
package replica_pkg;

    localparam int          NCITY_DEF = 32;
    localparam int          CITY_W    = 16;
    localparam logic [63:0] SEED_DEF  = 64'h0123_4567_89AB_CDEF;

    typedef logic [CITY_W-1:0] city_idx_t;

    typedef enum logic [1:0] {
        THR = 2'd0,
        TWO = 2'd1,
        OR0 = 2'd2,
        OR1 = 2'd3
    } opt_command_t;

    typedef struct packed {
        opt_command_t command;
        city_idx_t    k;
        city_idx_t    l;
        logic [22:0]  r_metropolis;
        logic [22:0]  r_exchange;
    } opt_t;

    typedef enum logic [1:0] {
        ST_GEN   = 2'd0,
        ST_FILL  = 2'd1,
        ST_READY = 2'd2
    } gen_state_t;

    localparam opt_t OPT_ZERO = '{
        command:      THR,
        k:            16'd0,
        l:            16'd0,
        r_metropolis: 23'd0,
        r_exchange:   23'd0
    };

    function automatic logic [63:0] xorshift64_step(input logic [63:0] x);
        logic [63:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 7);
        y = y ^ (y << 17);
        return y;
    endfunction

    // An all-zero state is a fixed point of xorshift, so it is replaced by 1.
    function automatic logic [63:0] nonzero_seed(input logic [63:0] s);
        logic [63:0] r;
        if (s == 64'd0) begin
            r = 64'd1;
        end else begin
            r = s;
        end
        return r;
    endfunction

endpackage

// File: rtl/xorshift64.sv
// 64-bit xorshift PRNG state with seed load (priority over stepping) and zero-seed guard.
module xorshift64
    import replica_pkg::*;
#(
    parameter logic [63:0] INIT = 64'h1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_i,
    input  logic [63:0] seed_i,
    input  logic        step_i,
    output logic        msb_o,
    output logic [45:0] low_o
);

    logic [63:0] state_q;
    logic [63:0] state_d;

    // Next state: load wins over step, otherwise hold.
    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = nonzero_seed(seed_i);
        end else if (step_i) begin
            state_d = xorshift64_step(state_q);
        end else begin
            state_d = state_q;
        end
    end

    // State register with synchronous reset to the guarded initial seed.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= nonzero_seed(INIT);
        end else begin
            state_q <= state_d;
        end
    end

    assign msb_o = state_q[63];
    assign low_o = state_q[45:0];

endmodule

// File: rtl/opt_gen.sv
// Per-replica move generator: rejection-samples K/L from xorshift64 and presents an opt_t
// behind a valid/ready handshake. Optional macro OPT_GEN_RETRY_LIMIT_EN bounds rejections.
module opt_gen
    import replica_pkg::*;
#(
    parameter int          id        = 0,
    parameter int          NCITY     = NCITY_DEF,
    parameter logic [63:0] SEED      = SEED_DEF,
    parameter int          RETRY_MAX = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        seed_load,
    input  logic [63:0] seed,
    input  logic        out_ready,
    output logic        out_valid,
    output opt_t        out_opt,
    output logic        busy
);

    localparam int CW = $clog2(NCITY);

    if (CW > CITY_W || CW < 1 || RETRY_MAX < 1) begin : g_bad_cfg
        $error("opt_gen: NCITY must give 1..16 index bits and RETRY_MAX must be positive");
    end

    gen_state_t   state_q, state_d;
    logic         rng_msb_s;
    logic [45:0]  rng_lo_s;
    logic [CW-1:0] k_s, l_s;
    logic         reject_s;
    logic         force_s;
    logic         accept_s;
    opt_command_t cmd_s;
    city_idx_t    k_q, k_d, l_q, l_d;
    opt_t         opt_q, opt_d;
    logic         valid_q, valid_d;
    logic         busy_q, busy_d;

    xorshift64 #(
        .INIT (SEED ^ 64'(unsigned'(id)))
    ) u_rng (
        .clk    (clk),
        .reset  (reset),
        .load_i (seed_load),
        .seed_i (seed),
        .step_i (state_q != ST_READY),
        .msb_o  (rng_msb_s),
        .low_o  (rng_lo_s)
    );

    assign k_s = rng_lo_s[CW-1:0];
    assign l_s = rng_lo_s[2*CW-1:CW];

    // Rejection test: both indices must be legal non-start cities and distinct.
    always_comb begin
        reject_s = 1'b0;
        if ((k_s == {CW{1'b0}}) || (l_s == {CW{1'b0}}) || (k_s == l_s) ||
            ({{(32-CW){1'b0}}, k_s} >= 32'(NCITY)) ||
            ({{(32-CW){1'b0}}, l_s} >= 32'(NCITY))) begin
            reject_s = 1'b1;
        end else begin
            reject_s = 1'b0;
        end
    end

`ifdef OPT_GEN_RETRY_LIMIT_EN
    localparam int RW = $clog2(RETRY_MAX + 1);
    logic [RW-1:0] rej_q, rej_d;
    logic          thr_q, thr_d;

    assign force_s = reject_s && (rej_q == RW'(RETRY_MAX - 1));

    // Consecutive-rejection counter and the forced-THR flag for the pending move.
    always_comb begin
        rej_d = rej_q;
        thr_d = thr_q;
        if (seed_load) begin
            rej_d = {RW{1'b0}};
            thr_d = 1'b0;
        end else if (state_q == ST_GEN) begin
            if (reject_s && !force_s) begin
                rej_d = rej_q + RW'(1);
            end else begin
                rej_d = {RW{1'b0}};
                thr_d = force_s;
            end
        end else begin
            rej_d = rej_q;
        end
    end

    // Retry counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rej_q <= {RW{1'b0}};
            thr_q <= 1'b0;
        end else begin
            rej_q <= rej_d;
            thr_q <= thr_d;
        end
    end

    assign cmd_s = thr_q ? THR : (rng_msb_s ? TWO : OR0);
`else
    assign force_s = 1'b0;
    assign cmd_s   = rng_msb_s ? TWO : OR0;
`endif

    assign accept_s = !reject_s || force_s;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_GEN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; a seed load restarts generation from any state.
    always_comb begin
        state_d = state_q;
        if (seed_load) begin
            state_d = ST_GEN;
        end else begin
            case (state_q)
                ST_GEN:   state_d = accept_s ? ST_FILL : ST_GEN;
                ST_FILL:  state_d = ST_READY;
                ST_READY: state_d = (valid_q && out_ready) ? ST_GEN : ST_READY;
                default:  state_d = ST_GEN;
            endcase
        end
    end

    // K/L capture on accept; a forced THR move carries K=L=0.
    always_comb begin
        k_d = k_q;
        l_d = l_q;
        if (!seed_load && (state_q == ST_GEN) && accept_s) begin
            k_d = reject_s ? CITY_W'(0) : city_idx_t'(k_s);
            l_d = reject_s ? CITY_W'(0) : city_idx_t'(l_s);
        end else begin
            k_d = k_q;
        end
    end

    // FSM outputs: the move record is only rebuilt on FILL->READY.
    always_comb begin
        opt_d   = opt_q;
        valid_d = (state_d == ST_READY);
        busy_d  = (state_d == ST_GEN) || (state_d == ST_FILL);
        if (!seed_load && (state_q == ST_FILL)) begin
            opt_d.command      = cmd_s;
            opt_d.k            = k_q;
            opt_d.l            = l_q;
            opt_d.r_metropolis = rng_lo_s[22:0];
            opt_d.r_exchange   = rng_lo_s[45:23];
        end else begin
            opt_d = opt_q;
        end
    end

    // Output and K/L registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            opt_q   <= OPT_ZERO;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            k_q     <= 16'd0;
            l_q     <= 16'd0;
        end else begin
            opt_q   <= opt_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            k_q     <= k_d;
            l_q     <= l_d;
        end
    end

    assign out_valid = valid_q;
    assign out_opt   = opt_q;
    assign busy      = busy_q;

endmodule
